mult_fu_pipe: RTL and testbench

Parametrised, pipelined integer multiplier functional unit with selectable low/high-half and signedness modes, CDB back-pressure, and branch-mask-based speculative squash. It is the next generation of the fixed 64-bit `pipe_mult_fu`. It sits between the multiply reservation-station issue port and the CDB arbiter. It accepts one operation per cycle and returns results in issue order, tagged with the destination physical register.

---
 rtl/mult_fu_pipe_pkg.sv | 29 ++
 rtl/mult_fu_pipe_stage.sv | 85 ++++++++
 rtl/mult_fu_pipe.sv | 98 +++++++++
 tb/tb_mult_fu_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_fu_pipe_pkg.sv
// Shared types and operand-signedness helpers for the pipelined multiply functional unit.
package mult_fu_pipe_pkg;

  localparam int XLEN_DEFAULT    = 64;
  localparam int TAG_W_DEFAULT   = 6;
  localparam int BMASK_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    MODE_LO    = 2'd0,
    MODE_HI_UU = 2'd1,
    MODE_HI_SS = 2'd2,
    MODE_HI_SU = 2'd3
  } MULT_MODE;

  typedef logic [XLEN_DEFAULT-1:0]    DATA;
  typedef logic [TAG_W_DEFAULT-1:0]   PHYS_REG;
  typedef logic [BMASK_W_DEFAULT-1:0] BMASK;

  // LO only needs the low half, which is the same under either extension,
  // so it takes the cheaper zero-extension path.
  function automatic logic op_a_signed(input MULT_MODE mode);
    return (mode == MODE_HI_SS) || (mode == MODE_HI_SU);
  endfunction

  function automatic logic op_b_signed(input MULT_MODE mode);
    return mode == MODE_HI_SS;
  endfunction

endpackage

// File: rtl/mult_fu_pipe_stage.sv
// One shift-and-add multiplier stage with its control register and
// branch-mask squash/resolve handling.
module mult_stage
  import mult_fu_pipe_pkg::*;
#(
  parameter int PW      = 128,
  parameter int CHUNK   = 32,
  parameter int TAG_W   = 6,
  parameter int BMASK_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               advance,
  input  logic               prev_valid,
  input  logic [TAG_W-1:0]   prev_tag,
  input  MULT_MODE           prev_mode,
  input  logic [BMASK_W-1:0] prev_bmask,
  input  logic [PW-1:0]      prev_sum,
  input  logic [PW-1:0]      prev_mcand,
  input  logic [PW-1:0]      prev_mplier,
  input  logic               br_resolve,
  input  logic               br_mispredict,
  input  logic [BMASK_W-1:0] br_bit,
  output logic               valid,
  output logic [TAG_W-1:0]   tag,
  output MULT_MODE           mode,
  output logic [BMASK_W-1:0] bmask,
  output logic [PW-1:0]      sum,
  output logic [PW-1:0]      mcand,
  output logic [PW-1:0]      mplier
);

  logic               resolving;
  logic               kill_prev;
  logic               kill_held;
  logic [BMASK_W-1:0] bmask_prev_upd;
  logic [BMASK_W-1:0] bmask_held_upd;
  logic [PW-1:0]      partial;

  // Mispredict wins when both branch strobes fire together.
  assign resolving      = br_resolve && !br_mispredict;
  assign kill_prev      = br_mispredict && ((prev_bmask & br_bit) != '0);
  assign kill_held      = br_mispredict && ((bmask & br_bit) != '0);
  assign bmask_prev_upd = resolving ? (prev_bmask & ~br_bit) : prev_bmask;
  assign bmask_held_upd = resolving ? (bmask & ~br_bit) : bmask;

  always_comb begin
    // NOTE: default assignment first so no path through the loop can infer a latch.
    partial = '0;
    for (int j = 0; j < CHUNK; j++) begin
      if (prev_mplier[j]) begin
        partial = partial + (prev_mcand << j);
      end
    end
  end

  // Squash and resolve act on whatever this register holds at the edge: the
  // op arriving from upstream when advancing, or the held op when stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every stage samples the pre-edge values
    // of its neighbour; blocking here would let an op race through several stages.
    if (!reset_n) begin
      // NOTE: datapath registers are reset too, so the outputs read zero during reset.
      valid  <= 1'b0;
      tag    <= '0;
      mode   <= MODE_LO;
      bmask  <= '0;
      sum    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (advance) begin
      valid  <= prev_valid && !kill_prev;
      tag    <= prev_tag;
      mode   <= prev_mode;
      bmask  <= bmask_prev_upd;
      sum    <= prev_sum + partial;
      mcand  <= prev_mcand << CHUNK;
      mplier <= prev_mplier >> CHUNK;
    end else begin
      valid  <= valid && !kill_held;
      bmask  <= bmask_held_upd;
    end
  end

endmodule

// File: rtl/mult_fu_pipe.sv
// Pipelined integer multiply functional unit: issue-side operand extension,
// STAGES shift-and-add stages, CDB-side result select and stall control.
module mult_fu_pipe
  import mult_fu_pipe_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int STAGES  = 4,
  parameter int TAG_W   = TAG_W_DEFAULT,
  parameter int BMASK_W = BMASK_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               fus_en,
  output logic               fus_ready,
  input  logic [XLEN-1:0]    fus_opA,
  input  logic [XLEN-1:0]    fus_opB,
  input  logic [1:0]         fus_mode,
  input  logic [TAG_W-1:0]   fus_tagDest,
  input  logic [BMASK_W-1:0] fus_bmask,
  input  logic               br_resolve,
  input  logic               br_mispredict,
  input  logic [BMASK_W-1:0] br_bit,
  input  logic               cdb_grant,
  output logic               mult_done,
  output logic [XLEN-1:0]    mult_result,
  output logic [TAG_W-1:0]   mult_tagDest,
  output logic [BMASK_W-1:0] mult_bmask
);

  localparam int PW    = 2 * XLEN;
  localparam int CHUNK = PW / STAGES;

  // Index 0 is the issue port; index STAGES is the output register.
  logic               valid_q  [0:STAGES];
  logic [TAG_W-1:0]   tag_q    [0:STAGES];
  MULT_MODE           mode_q   [0:STAGES];
  logic [BMASK_W-1:0] bmask_q  [0:STAGES];
  logic [PW-1:0]      sum_q    [0:STAGES];
  logic [PW-1:0]      mcand_q  [0:STAGES];
  logic [PW-1:0]      mplier_q [0:STAGES];

  logic advance;
  logic out_dying;

  // Ready deliberately ignores a squash of the output op: it frees at the next edge.
  assign advance   = !valid_q[STAGES] || cdb_grant;
  assign fus_ready = advance;

  // Stage 0 only captures on advance, so fus_en while stalled is dropped there.
  assign valid_q[0]  = fus_en;
  assign tag_q[0]    = fus_tagDest;
  assign mode_q[0]   = MULT_MODE'(fus_mode);
  assign bmask_q[0]  = fus_bmask;
  assign sum_q[0]    = '0;
  assign mcand_q[0]  = op_a_signed(mode_q[0]) ? {{XLEN{fus_opA[XLEN-1]}}, fus_opA}
                                              : {{XLEN{1'b0}}, fus_opA};
  assign mplier_q[0] = op_b_signed(mode_q[0]) ? {{XLEN{fus_opB[XLEN-1]}}, fus_opB}
                                              : {{XLEN{1'b0}}, fus_opB};

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    mult_stage #(
      .PW      (PW),
      .CHUNK   (CHUNK),
      .TAG_W   (TAG_W),
      .BMASK_W (BMASK_W)
    ) u_stage (
      .clk           (clk),
      .reset_n       (reset_n),
      .advance       (advance),
      .prev_valid    (valid_q[i]),
      .prev_tag      (tag_q[i]),
      .prev_mode     (mode_q[i]),
      .prev_bmask    (bmask_q[i]),
      .prev_sum      (sum_q[i]),
      .prev_mcand    (mcand_q[i]),
      .prev_mplier   (mplier_q[i]),
      .br_resolve    (br_resolve),
      .br_mispredict (br_mispredict),
      .br_bit        (br_bit),
      .valid         (valid_q[i+1]),
      .tag           (tag_q[i+1]),
      .mode          (mode_q[i+1]),
      .bmask         (bmask_q[i+1]),
      .sum           (sum_q[i+1]),
      .mcand         (mcand_q[i+1]),
      .mplier        (mplier_q[i+1])
    );
  end

  // An output op killed by this cycle's mispredict must never reach the CDB.
  assign out_dying    = br_mispredict && ((bmask_q[STAGES] & br_bit) != '0);
  assign mult_done    = valid_q[STAGES] && !out_dying;
  assign mult_result  = (mode_q[STAGES] == MODE_LO) ? sum_q[STAGES][XLEN-1:0]
                                                    : sum_q[STAGES][PW-1:XLEN];
  assign mult_tagDest = tag_q[STAGES];
  assign mult_bmask   = bmask_q[STAGES];

endmodule

// File: tb/tb_mult_fu_pipe.sv
// Self-checking bench for mult_fu_pipe: constant vector table, directed
// stall/squash/resolve/reset sequences, and a randomized run against a queue model.
module tb_mult_fu_pipe;
  import mult_fu_pipe_pkg::*;

  localparam int XLEN    = 64;
  localparam int STAGES  = 4;
  localparam int TAG_W   = 6;
  localparam int BMASK_W = 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               fus_en;
  logic               fus_ready;
  logic [XLEN-1:0]    fus_opA;
  logic [XLEN-1:0]    fus_opB;
  logic [1:0]         fus_mode;
  logic [TAG_W-1:0]   fus_tagDest;
  logic [BMASK_W-1:0] fus_bmask;
  logic               br_resolve;
  logic               br_mispredict;
  logic [BMASK_W-1:0] br_bit;
  logic               cdb_grant;
  logic               mult_done;
  logic [XLEN-1:0]    mult_result;
  logic [TAG_W-1:0]   mult_tagDest;
  logic [BMASK_W-1:0] mult_bmask;

  always #5 clk = ~clk;

  mult_fu_pipe #(
    .XLEN    (XLEN),
    .STAGES  (STAGES),
    .TAG_W   (TAG_W),
    .BMASK_W (BMASK_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fus_en        (fus_en),
    .fus_ready     (fus_ready),
    .fus_opA       (fus_opA),
    .fus_opB       (fus_opB),
    .fus_mode      (fus_mode),
    .fus_tagDest   (fus_tagDest),
    .fus_bmask     (fus_bmask),
    .br_resolve    (br_resolve),
    .br_mispredict (br_mispredict),
    .br_bit        (br_bit),
    .cdb_grant     (cdb_grant),
    .mult_done     (mult_done),
    .mult_result   (mult_result),
    .mult_tagDest  (mult_tagDest),
    .mult_bmask    (mult_bmask)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  logic [TAG_W-1:0] done_tags[$];

  // Model entry: an in-flight op and how many advancing edges it has seen.
  typedef struct {
    logic [XLEN-1:0]    res;
    logic [TAG_W-1:0]   tag;
    logic [BMASK_W-1:0] mask;
    int                 pos;
  } ent_t;
  ent_t q[$];

  typedef struct {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [1:0]      mode;
    logic [XLEN-1:0] exp;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                               input logic [1:0] mode);
    logic [2*XLEN-1:0] ea, eb, p;
    ea = (mode == 2'd2 || mode == 2'd3) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    eb = (mode == 2'd2) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    p  = ea * eb;
    return (mode == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'd0;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic idle_inputs();
    fus_en        = 1'b0;
    fus_opA       = '0;
    fus_opB       = '0;
    fus_mode      = 2'd0;
    fus_tagDest   = '0;
    fus_bmask     = '0;
    br_resolve    = 1'b0;
    br_mispredict = 1'b0;
    br_bit        = '0;
    cdb_grant     = 1'b1;
  endtask

  // One clock: compare outputs with the model at the falling edge, advance the
  // model with this cycle's inputs, then return 1 ns after the rising edge.
  task automatic step();
    logic occ, exp_ready, exp_done;
    ent_t e;
    ent_t nq[$];
    @(negedge clk);
    occ       = (q.size() > 0) && (q[0].pos == STAGES);
    exp_ready = !occ || cdb_grant;
    exp_done  = occ && !(br_mispredict && ((q[0].mask & br_bit) != '0));
    check("fus_ready", 64'(fus_ready), 64'(exp_ready));
    check("mult_done", 64'(mult_done), 64'(exp_done));
    if (exp_done && mult_done === 1'b1) begin
      check("mult_result", mult_result, q[0].res);
      check("mult_tagDest", 64'(mult_tagDest), 64'(q[0].tag));
      check("mult_bmask", 64'(mult_bmask), 64'(q[0].mask));
    end
    if (mult_done === 1'b1 && cdb_grant) begin
      n_done++;
      done_tags.push_back(mult_tagDest);
    end
    if (exp_done && cdb_grant) void'(q.pop_front());
    if (exp_ready) begin
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        e.pos++;
        q[i] = e;
      end
      if (fus_en) begin
        e.res  = ref_mul(fus_opA, fus_opB, fus_mode);
        e.tag  = fus_tagDest;
        e.mask = fus_bmask;
        e.pos  = 1;
        q.push_back(e);
      end
    end
    if (br_mispredict) begin
      foreach (q[i]) if ((q[i].mask & br_bit) == '0) nq.push_back(q[i]);
      q = nq;
    end else if (br_resolve) begin
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        e.mask = e.mask & ~br_bit;
        q[i] = e;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [1:0] mode,
                       input logic [TAG_W-1:0] tag, input logic [BMASK_W-1:0] mask);
    fus_en      = 1'b1;
    fus_opA     = a;
    fus_opB     = b;
    fus_mode    = mode;
    fus_tagDest = tag;
    fus_bmask   = mask;
    step();
    fus_en      = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vecs[0]  = '{64'd2, 64'd3, 2'd0, 64'd6};
    vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 64'd1};
    vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 64'd0};
    vecs[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[4]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5]  = '{64'h8000_0000_0000_0000, 64'd2, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6]  = '{64'h8000_0000_0000_0000, 64'd2, 2'd1, 64'd1};
    vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 2'd0, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 2'd1, 64'd4};
    vecs[9]  = '{64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 2'd3, 64'd4};
    vecs[10] = '{64'h1_0000_0000, 64'h1_0000_0000, 2'd1, 64'd1};
    vecs[11] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 64'd0};

    // Reset state.
    idle_inputs();
    reset_n = 1'b0;
    #2;
    check("reset_done", 64'(mult_done), 64'd0);
    check("reset_ready", 64'(fus_ready), 64'd1);
    check("reset_result", mult_result, 64'd0);
    check("reset_tag", 64'(mult_tagDest), 64'd0);
    check("reset_bmask", 64'(mult_bmask), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    q.delete();

    // Vector table: result value and no-stall latency.
    foreach (vecs[v]) begin
      issue(vecs[v].a, vecs[v].b, vecs[v].mode, TAG_W'(v + 1), '0);
      lat = 1;
      while (mult_done !== 1'b1 && lat < 4 * STAGES) begin
        step();
        lat++;
      end
      check("vec_latency", 64'(lat), 64'(STAGES));
      check("vec_result", mult_result, vecs[v].exp);
      check("vec_tag", 64'(mult_tagDest), 64'(v + 1));
      step();
    end

    // Back-to-back issue into a stalled CDB, then drain in order.
    cdb_grant = 1'b0;
    for (int i = 0; i < 4; i++) issue(64'(i + 10), 64'(i + 100), 2'd0, TAG_W'(20 + i), '0);
    fus_en = 1'b1;
    fus_opA = 64'd7;
    fus_opB = 64'd7;
    fus_tagDest = 6'd63;
    repeat (3) step();
    check("stall_ready", 64'(fus_ready), 64'd0);
    check("stall_done", 64'(mult_done), 64'd1);
    check("stall_result", mult_result, 64'd1000);
    check("stall_tag", 64'(mult_tagDest), 64'd20);
    fus_en = 1'b0;
    cdb_grant = 1'b1;
    n_done = 0;
    done_tags.delete();
    repeat (5) step();
    check("stall_drain_count", 64'(n_done), 64'd4);
    for (int i = 0; i < 4 && i < done_tags.size(); i++)
      check("stall_drain_order", 64'(done_tags[i]), 64'(20 + i));

    // Mispredict kills only the dependent op.
    n_done = 0;
    done_tags.delete();
    issue(64'd3, 64'd3, 2'd0, 6'd30, 4'b0001);
    issue(64'd4, 64'd4, 2'd0, 6'd31, 4'b0010);
    issue(64'd5, 64'd5, 2'd0, 6'd32, 4'b0000);
    br_mispredict = 1'b1;
    br_bit = 4'b0001;
    step();
    br_mispredict = 1'b0;
    br_bit = '0;
    repeat (8) step();
    check("squash_count", 64'(n_done), 64'd2);
    if (done_tags.size() == 2) begin
      check("squash_first", 64'(done_tags[0]), 64'd31);
      check("squash_second", 64'(done_tags[1]), 64'd32);
    end

    // Correct resolve clears the bit from the in-flight mask.
    issue(64'd6, 64'd9, 2'd0, 6'd40, 4'b0010);
    br_resolve = 1'b1;
    br_bit = 4'b0010;
    step();
    br_resolve = 1'b0;
    br_bit = '0;
    lat = 0;
    while (mult_done !== 1'b1 && lat < 4 * STAGES) begin
      step();
      lat++;
    end
    check("resolve_done", 64'(mult_done), 64'd1);
    check("resolve_bmask", 64'(mult_bmask), 64'd0);
    check("resolve_result", mult_result, 64'd54);
    step();

    // Asynchronous reset while an op waits at the output.
    cdb_grant = 1'b0;
    for (int i = 0; i < 3; i++) issue(64'(i + 2), 64'd11, 2'd0, TAG_W'(50 + i), '0);
    step();
    check("pre_reset_done", 64'(mult_done), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_done", 64'(mult_done), 64'd0);
    check("async_reset_ready", 64'(fus_ready), 64'd1);
    check("async_reset_result", mult_result, 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cdb_grant = 1'b1;
    n_done = 0;
    repeat (10) step();
    check("post_reset_completions", 64'(n_done), 64'd0);

    // Randomized traffic with stalls, squashes and resolves.
    for (int c = 0; c < 14000; c++) begin
      fus_en        = ($urandom_range(0, 99) < 70);
      fus_opA       = rand_op();
      fus_opB       = rand_op();
      fus_mode      = 2'($urandom_range(0, 3));
      fus_tagDest   = TAG_W'($urandom());
      fus_bmask     = ($urandom_range(0, 1) == 0) ? '0 : BMASK_W'($urandom());
      cdb_grant     = ($urandom_range(0, 99) < 75);
      br_mispredict = ($urandom_range(0, 99) < 3);
      br_resolve    = ($urandom_range(0, 99) < 6);
      br_bit        = BMASK_W'(1 << $urandom_range(0, BMASK_W - 1));
      step();
    end
    idle_inputs();
    for (int c = 0; c < 10 * STAGES && q.size() > 0; c++) step();
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
